branch_predict_unit: RTL

Parametrised successor to the execute-stage branch resolver. It resolves jumps and conditional branches in execute and keeps a direct-mapped branch target buffer (BTB) with 2-bit saturating counters that predicts fetch-stage redirects. It reports a mispredict redirect back to fetch and keeps saturating performance counters. It sits between the fetch PC mux and the execute stage of the uDLX pipeline.

---
 rtl/branch_predict_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolver with a direct-mapped BTB (2-bit counters),
// a mispredict redirect back to fetch, and saturating statistics counters.
module branch_predict_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int PC_WIDTH    = 6,
    parameter int INDEX_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  if_pred_taken,
    output logic [PC_WIDTH-1:0]   if_pred_target,
    input  logic                  ex_valid,
    input  logic                  ex_jmp_inst,
    input  logic                  ex_jmp_use_r,
    input  logic                  ex_branch_inst,
    input  logic                  ex_branch_result,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_reg_a_data,
    input  logic [DATA_WIDTH-1:0] ex_reg_b_data,
    input  logic [DATA_WIDTH-1:0] ex_constant,
    input  logic                  ex_pred_taken,
    input  logic [PC_WIDTH-1:0]   ex_pred_target,
    output logic                  redirect_valid,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  ctrl_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int ENTRIES   = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;

    // BTB storage
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_d [ENTRIES];
    logic [PC_WIDTH-1:0]  tgt_q [ENTRIES];
    logic [PC_WIDTH-1:0]  tgt_d [ENTRIES];
    logic [1:0]           ctr_q [ENTRIES];
    logic [1:0]           ctr_d [ENTRIES];

    logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

    // Resolution signals
    logic                  actual_taken;
    logic                  is_ctrl;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] target_full;
    logic [PC_WIDTH-1:0]   actual_target;
    logic [PC_WIDTH-1:0]   fallthrough;

    // Lookup / update addressing
    logic [INDEX_WIDTH-1:0] idx_if, idx_ex;
    logic [TAG_WIDTH-1:0]   tag_if, tag_ex;
    logic                   hit_if, hit_ex;

    // Only the low PC bits of a computed target are meaningful.
    logic unused_target_hi;
    assign unused_target_hi = ^target_full[DATA_WIDTH-1:PC_WIDTH];

    // Resolve the execute-stage instruction: direction, target and mispredict.
    always_comb begin
        actual_taken = ex_jmp_inst | (ex_branch_inst & ex_branch_result);
        is_ctrl      = ex_jmp_inst | ex_branch_inst;
        if (ex_jmp_inst) begin
            target_full = ex_jmp_use_r ? ex_reg_a_data : ex_constant;
        end else begin
            target_full = DATA_WIDTH'(ex_pc) + ex_reg_b_data;
        end
        actual_target  = target_full[PC_WIDTH-1:0];
        fallthrough    = ex_pc + PC_WIDTH'(1);
        mispredict     = ex_valid & ((ex_pred_taken != actual_taken) |
                                     (actual_taken & (ex_pred_target != actual_target)));
        redirect_valid = mispredict;
        redirect_pc    = actual_taken ? actual_target : fallthrough;
    end

    // Fetch-side prediction from the registered table (no bypass of updates).
    always_comb begin
        idx_if         = if_pc[INDEX_WIDTH-1:0];
        tag_if         = if_pc[PC_WIDTH-1:INDEX_WIDTH];
        hit_if         = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        if_pred_taken  = hit_if & ctr_q[idx_if][1];
        if_pred_target = if_pred_taken ? tgt_q[idx_if] : if_pc + PC_WIDTH'(1);
    end

    // Next table contents: allocate on a taken miss, train the counter on a hit.
    always_comb begin
        idx_ex  = ex_pc[INDEX_WIDTH-1:0];
        tag_ex  = ex_pc[PC_WIDTH-1:INDEX_WIDTH];
        hit_ex  = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (ex_valid && is_ctrl) begin
            if (hit_ex) begin
                if (ex_jmp_inst) begin
                    ctr_d[idx_ex] = 2'b11;
                    tgt_d[idx_ex] = actual_target;
                end else if (ex_branch_result) begin
                    if (ctr_q[idx_ex] != 2'b11) begin
                        ctr_d[idx_ex] = ctr_q[idx_ex] + 2'b01;
                    end
                    tgt_d[idx_ex] = actual_target;
                end else if (ctr_q[idx_ex] != 2'b00) begin
                    ctr_d[idx_ex] = ctr_q[idx_ex] - 2'b01;
                end
            end else if (actual_taken) begin
                valid_d[idx_ex] = 1'b1;
                tag_d[idx_ex]   = tag_ex;
                tgt_d[idx_ex]   = actual_target;
                ctr_d[idx_ex]   = ex_jmp_inst ? 2'b11 : 2'b10;
            end
        end
    end

    // Statistics: saturating increments, clear wins over a same-cycle event.
    always_comb begin
        ctrl_cnt_d = ctrl_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (stat_clear) begin
            ctrl_cnt_d = '0;
            misp_cnt_d = '0;
        end else begin
            if (ex_valid && is_ctrl && (ctrl_cnt_q != '1)) begin
                ctrl_cnt_d = ctrl_cnt_q + CNT_WIDTH'(1);
            end
            if (mispredict && (misp_cnt_q != '1)) begin
                misp_cnt_d = misp_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers for the table and the statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b00;
            end
            ctrl_cnt_q <= '0;
            misp_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            tgt_q      <= tgt_d;
            ctr_q      <= ctr_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign ctrl_count       = ctrl_cnt_q;
    assign mispredict_count = misp_cnt_q;

endmodule
